i2c_write_arbiter: RTL and testbench
====================================

I2C_WRITE_ARBITER -- requirements
Module: i2c_write_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 100000; the number of clk cycles allowed from eng_start to eng_done; legal values are 2 or greater.
REQ-002 The block SHALL have parameter RR, default 0; 0 selects fixed priority (port 0 wins), 1 selects round-robin.
REQ-003 The block SHALL have port clk, input, 1 bit; the single clock, with all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit; asynchronous, active-low reset.
REQ-005 The block SHALL have port req0, input, 1 bit; level request from port 0, held until done0 or err0.
REQ-006 The block SHALL have port data0, input, 24 bits; the port 0 write word {device addr, register addr, value}.
REQ-007 The block SHALL have port done0, output, 1 bit; a one-cycle pulse when the port 0 write completes.
REQ-008 The block SHALL have port err0, output, 1 bit; a one-cycle pulse when the port 0 write times out.
REQ-009 The block SHALL have ports req1, data1, done1 and err1, identical in direction, width and meaning to the port 0 set, for port 1.
REQ-010 The block SHALL have port eng_start, output, 1 bit; a one-cycle start pulse to the I2C write engine.
REQ-011 The block SHALL have port eng_data, output, 24 bits; the word sent to the engine, held stable from eng_start until the transaction ends.
REQ-012 The block SHALL have port eng_done, input, 1 bit; a one-cycle completion pulse from the engine, already synchronous to clk.
REQ-013 The block SHALL have port busy, output, 1 bit; high whenever the state is not IDLE.
REQ-014 The block SHALL have port grant, output, 1 bit; the index of the current or most recent owner.

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE, WAIT and RELEASE.
REQ-016 In IDLE with any request asserted, the block SHALL select a winner, latch that port's data into eng_data, set grant to the winner and move to ISSUE.
REQ-017 With RR=0, the block SHALL give port 0 the win on simultaneous requests.
REQ-018 With RR=1, the block SHALL give the win on simultaneous requests to the port that was not the last owner; after reset, port 0 is favoured.
REQ-019 In ISSUE, the block SHALL drive eng_start high for exactly one cycle, clear the timer and move to WAIT.
REQ-020 Latency: a request sampled in IDLE at cycle N SHALL produce eng_start high in cycle N+1.
REQ-021 In WAIT, when eng_done is seen at cycle M, the block SHALL pulse the owner's done in cycle M+1 and enter RELEASE.
REQ-022 In WAIT, the timer SHALL increment every cycle; when it reaches TIMEOUT-1 without eng_done, the block SHALL pulse the owner's err the next cycle and enter RELEASE.
REQ-023 If eng_done and timer expiry occur in the same cycle, done SHALL win and err SHALL NOT pulse.
REQ-024 RELEASE SHALL last one cycle, SHALL ignore requests and SHALL then return to IDLE; this lets the owner drop req after done/err without being re-served.
REQ-025 The block SHALL ignore eng_done outside WAIT.
REQ-026 The block SHALL ignore changes to data0/data1 after latching.
REQ-027 The block SHALL never pulse done and err for the same transaction.
REQ-028 The block SHALL issue at most one eng_start per grant.
REQ-029 The timer width SHALL be clog2(TIMEOUT) bits and the timer SHALL NOT wrap inside WAIT.
REQ-030 A request that deasserts before it is granted SHALL be dropped, with no done or err pulse.

Reset
REQ-031 reset low SHALL immediately force: state IDLE, eng_start 0, eng_data 24'h000000, done0/done1/err0/err1 0, busy 0, grant 0, round-robin pointer favouring port 0, timer 0.
REQ-032 Reset asserted mid-transaction SHALL abandon that transaction with no done or err pulse.
REQ-033 An eng_done arriving after reset is released SHALL be ignored unless the block is in WAIT.
REQ-034 The first request after reset is released SHALL be served with the REQ-020 latency.

Verification
REQ-035 Single write: req0 with data0=24'h729803, eng_done 5 cycles after eng_start -> eng_start one cycle after the req sample, eng_data=24'h729803, one done0 pulse, done1/err0/err1 never high.
REQ-036 Simultaneous requests, RR=0: req0 (24'h721630) and req1 (24'h72af16) together -> port 0 served first, then port 1, exactly two eng_start pulses, grant 0 then 1.
REQ-037 Continuous contention, RR=1: both requests held for 4 transactions -> grant sequence 0,1,0,1 with one done pulse each.
REQ-038 Timeout: TIMEOUT=16 with no eng_done -> err0 pulses 16 cycles after eng_start, done0 stays low, busy low within 2 further cycles.
REQ-039 Collision: eng_done in the same cycle as timer expiry -> done0 pulses and err0 does not.
REQ-040 Reset mid-operation: reset driven low during WAIT -> all outputs 0 asynchronously; a late eng_done after release produces no pulse.

Source files
------------

// File: rtl/i2c_write_arbiter.sv
// rtl/i2c_write_arbiter.sv - two-port write arbiter in front of a single I2C write engine
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   req0/req1           level requests, held by the requester until its done/err
//   data0/data1         24-bit write words {device addr, register addr, value}
//   done0/done1         one-cycle completion pulse to the owning port
//   err0/err1           one-cycle timeout pulse to the owning port
//   eng_start           one-cycle start pulse to the engine
//   eng_data            word latched at grant, stable until the transaction ends
//   eng_done            one-cycle completion pulse from the engine
//   busy                high whenever the FSM is not idle
//   grant               index of the current or most recent owner
module i2c_write_arbiter #(
  parameter int TIMEOUT = 100000,
  parameter int RR      = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [23:0] data0,
  output logic        done0,
  output logic        err0,
  input  logic        req1,
  input  logic [23:0] data1,
  output logic        done1,
  output logic        err1,
  output logic        eng_start,
  output logic [23:0] eng_data,
  input  logic        eng_done,
  output logic        busy,
  output logic        grant
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_inc;
  logic          rr_pref;       // port favoured on the next tie
  logic          outcome_done;  // 1: released on eng_done, 0: released on timeout
  logic          any_req;
  logic          winner;
  logic          timer_hit;

  assign any_req   = req0 | req1;
  assign timer_inc = timer + TW'(1);
  // Expiry is judged on the incremented value so that the error pulse lands
  // exactly TIMEOUT cycles after eng_start.
  assign timer_hit = (timer_inc == TIMER_LAST);

  always_comb begin
    winner = 1'b0;
    if (req0 && req1) begin
      winner = (RR != 0) ? rr_pref : 1'b0;
    end else begin
      winner = req1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers: grant, latched word, tie-break pointer, timer, outcome
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant        <= 1'b0;
      eng_data     <= 24'h000000;
      rr_pref      <= 1'b0;
      timer        <= '0;
      outcome_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant    <= winner;
            eng_data <= winner ? data1 : data0;
            rr_pref  <= ~winner;
          end
        end
        ISSUE: begin
          timer <= '0;
        end
        WAIT: begin
          timer <= timer_inc;
          // eng_done takes precedence over a coincident expiry
          if (eng_done) begin
            outcome_done <= 1'b1;
          end else if (timer_hit) begin
            outcome_done <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (eng_done || timer_hit) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state so that reset clears them without a clock edge
  always_comb begin
    busy      = (state != IDLE);
    eng_start = (state == ISSUE);
    done0     = 1'b0;
    done1     = 1'b0;
    err0      = 1'b0;
    err1      = 1'b0;
    if (state == RELEASE) begin
      done0 = outcome_done  & ~grant;
      done1 = outcome_done  &  grant;
      err0  = ~outcome_done & ~grant;
      err1  = ~outcome_done &  grant;
    end
  end

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// tb/tb_i2c_write_arbiter.sv - directed bench for i2c_write_arbiter
module tb_i2c_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] data0, data1;
  logic        eng_done;

  logic        a_req0, a_req1, a_done0, a_done1, a_err0, a_err1;
  logic        a_eng_start, a_busy, a_grant;
  logic [23:0] a_eng_data;
  logic        b_req0, b_req1, b_done0, b_done1, b_err0, b_err1;
  logic        b_eng_start, b_busy, b_grant;
  logic [23:0] b_eng_data;

  int vectors = 0;
  int miscompares = 0;
  int a_starts = 0, a_d0 = 0, a_d1 = 0, a_e0 = 0, a_e1 = 0;
  int b_starts = 0, b_d0 = 0, b_d1 = 0, b_e0 = 0, b_e1 = 0;

  always #5 clk = ~clk;

  i2c_write_arbiter #(.TIMEOUT(16), .RR(0)) dut_a (
    .clk(clk), .reset(reset),
    .req0(a_req0), .data0(data0), .done0(a_done0), .err0(a_err0),
    .req1(a_req1), .data1(data1), .done1(a_done1), .err1(a_err1),
    .eng_start(a_eng_start), .eng_data(a_eng_data), .eng_done(eng_done),
    .busy(a_busy), .grant(a_grant)
  );

  i2c_write_arbiter #(.TIMEOUT(16), .RR(1)) dut_b (
    .clk(clk), .reset(reset),
    .req0(b_req0), .data0(data0), .done0(b_done0), .err0(b_err0),
    .req1(b_req1), .data1(data1), .done1(b_done1), .err1(b_err1),
    .eng_start(b_eng_start), .eng_data(b_eng_data), .eng_done(eng_done),
    .busy(b_busy), .grant(b_grant)
  );

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (a_eng_start) a_starts++;
    if (a_done0) a_d0++;
    if (a_done1) a_d1++;
    if (a_err0) a_e0++;
    if (a_err1) a_e1++;
    if (b_eng_start) b_starts++;
    if (b_done0) b_d0++;
    if (b_done1) b_d1++;
    if (b_err0) b_e0++;
    if (b_err1) b_e1++;
  end

  task automatic test_reset();
    a_req0 = 0; a_req1 = 0; b_req0 = 0; b_req1 = 0;
    eng_done = 0; data0 = 24'h0; data1 = 24'h0;
    repeat (2) @(negedge clk);
    vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    vectors++; if (a_eng_start !== 1'b0) begin miscompares++; $display("FAIL reset_start: got %b want 0", a_eng_start); end
    vectors++; if (a_eng_data !== 24'h000000) begin miscompares++; $display("FAIL reset_data: got %h want 000000", a_eng_data); end
    vectors++; if (a_grant !== 1'b0) begin miscompares++; $display("FAIL reset_grant: got %b want 0", a_grant); end
    vectors++; if ({a_done0, a_done1, a_err0, a_err1} !== 4'b0000) begin miscompares++; $display("FAIL reset_pulses: got %b want 0000", {a_done0, a_done1, a_err0, a_err1}); end
    vectors++; if (b_busy !== 1'b0) begin miscompares++; $display("FAIL reset_b_busy: got %b want 0", b_busy); end
    reset = 1;
    repeat (2) @(negedge clk);
    vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle: got %b want 0", a_busy); end
  endtask

  task automatic test_single_write();
    int s, d0, d1, e0, e1;
    s = a_starts; d0 = a_d0; d1 = a_d1; e0 = a_e0; e1 = a_e1;
    data0 = 24'h729803; a_req0 = 1;
    @(negedge clk);
    vectors++; if (a_eng_start !== 1'b1) begin miscompares++; $display("FAIL single_latency: got %b want 1", a_eng_start); end
    vectors++; if (a_eng_data !== 24'h729803) begin miscompares++; $display("FAIL single_data: got %h want 729803", a_eng_data); end
    vectors++; if (a_grant !== 1'b0) begin miscompares++; $display("FAIL single_grant: got %b want 0", a_grant); end
    vectors++; if (a_busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b want 1", a_busy); end
    data0 = 24'hffffff;
    repeat (5) @(negedge clk);
    eng_done = 1;
    @(negedge clk);
    eng_done = 0;
    vectors++; if (a_done0 !== 1'b1) begin miscompares++; $display("FAIL single_done0: got %b want 1", a_done0); end
    vectors++; if (a_eng_data !== 24'h729803) begin miscompares++; $display("FAIL single_data_held: got %h want 729803", a_eng_data); end
    a_req0 = 0;
    @(negedge clk);
    vectors++; if ({a_done0, a_busy} !== 2'b00) begin miscompares++; $display("FAIL single_release: got %b want 00", {a_done0, a_busy}); end
    repeat (3) @(negedge clk);
    vectors++; if (a_starts - s !== 1) begin miscompares++; $display("FAIL single_start_count: got %0d want 1", a_starts - s); end
    vectors++; if (a_d0 - d0 !== 1) begin miscompares++; $display("FAIL single_done0_count: got %0d want 1", a_d0 - d0); end
    vectors++; if ((a_d1 - d1) + (a_e0 - e0) + (a_e1 - e1) !== 0) begin miscompares++; $display("FAIL single_other_pulses: got %0d want 0", (a_d1 - d1) + (a_e0 - e0) + (a_e1 - e1)); end
  endtask

  task automatic test_simultaneous();
    int s, d0, d1, n;
    s = a_starts; d0 = a_d0; d1 = a_d1;
    data0 = 24'h721630; data1 = 24'h72af16; a_req0 = 1; a_req1 = 1;
    @(negedge clk);
    vectors++; if ({a_eng_start, a_grant} !== 2'b10) begin miscompares++; $display("FAIL sim_first_grant: got %b want 10", {a_eng_start, a_grant}); end
    vectors++; if (a_eng_data !== 24'h721630) begin miscompares++; $display("FAIL sim_first_data: got %h want 721630", a_eng_data); end
    repeat (2) @(negedge clk);
    eng_done = 1;
    @(negedge clk);
    eng_done = 0;
    vectors++; if ({a_done0, a_done1} !== 2'b10) begin miscompares++; $display("FAIL sim_first_done: got %b want 10", {a_done0, a_done1}); end
    a_req0 = 0;
    n = 0;
    while (!a_eng_start && n < 10) begin @(negedge clk); n++; end
    vectors++; if (n !== 2) begin miscompares++; $display("FAIL sim_second_start_gap: got %0d want 2", n); end
    vectors++; if (a_grant !== 1'b1) begin miscompares++; $display("FAIL sim_second_grant: got %b want 1", a_grant); end
    vectors++; if (a_eng_data !== 24'h72af16) begin miscompares++; $display("FAIL sim_second_data: got %h want 72af16", a_eng_data); end
    repeat (2) @(negedge clk);
    eng_done = 1;
    @(negedge clk);
    eng_done = 0;
    vectors++; if ({a_done0, a_done1} !== 2'b01) begin miscompares++; $display("FAIL sim_second_done: got %b want 01", {a_done0, a_done1}); end
    a_req1 = 0;
    repeat (3) @(negedge clk);
    vectors++; if (a_starts - s !== 2) begin miscompares++; $display("FAIL sim_start_count: got %0d want 2", a_starts - s); end
    vectors++; if ((a_d0 - d0) * 10 + (a_d1 - d1) !== 11) begin miscompares++; $display("FAIL sim_done_counts: got d0=%0d d1=%0d want 1 1", a_d0 - d0, a_d1 - d1); end
  endtask

  task automatic test_timeout();
    int d0, e0;
    d0 = a_d0; e0 = a_e0;
    data0 = 24'h720055; a_req0 = 1;
    @(negedge clk);
    vectors++; if (a_eng_start !== 1'b1) begin miscompares++; $display("FAIL timeout_start: got %b want 1", a_eng_start); end
    repeat (15) @(negedge clk);
    vectors++; if ({a_err0, a_busy} !== 2'b01) begin miscompares++; $display("FAIL timeout_early: got err0,busy=%b want 01", {a_err0, a_busy}); end
    @(negedge clk);
    vectors++; if ({a_err0, a_done0} !== 2'b10) begin miscompares++; $display("FAIL timeout_err0: got err0,done0=%b want 10", {a_err0, a_done0}); end
    a_req0 = 0;
    @(negedge clk);
    vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL timeout_busy_drop: got %b want 0", a_busy); end
    repeat (2) @(negedge clk);
    vectors++; if ((a_e0 - e0) * 10 + (a_d0 - d0) !== 10) begin miscompares++; $display("FAIL timeout_counts: got e0=%0d d0=%0d want 1 0", a_e0 - e0, a_d0 - d0); end
  endtask

  task automatic test_collision();
    int d0, e0;
    d0 = a_d0; e0 = a_e0;
    data0 = 24'h72c011; a_req0 = 1;
    @(negedge clk);
    vectors++; if (a_eng_start !== 1'b1) begin miscompares++; $display("FAIL collision_start: got %b want 1", a_eng_start); end
    repeat (15) @(negedge clk);
    eng_done = 1;
    @(negedge clk);
    eng_done = 0;
    vectors++; if ({a_done0, a_err0} !== 2'b10) begin miscompares++; $display("FAIL collision_pulse: got done0,err0=%b want 10", {a_done0, a_err0}); end
    a_req0 = 0;
    repeat (3) @(negedge clk);
    vectors++; if ((a_d0 - d0) * 10 + (a_e0 - e0) !== 10) begin miscompares++; $display("FAIL collision_counts: got d0=%0d e0=%0d want 1 0", a_d0 - d0, a_e0 - e0); end
  endtask

  task automatic test_reset_mid();
    int s, d0, d1, e0, e1;
    s = a_starts; d0 = a_d0; d1 = a_d1; e0 = a_e0; e1 = a_e1;
    data1 = 24'h7233cc; a_req1 = 1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    vectors++; if ({a_busy, a_grant} !== 2'b11) begin miscompares++; $display("FAIL midreset_pre: got busy,grant=%b want 11", {a_busy, a_grant}); end
    #2 reset = 0;
    #1;
    vectors++; if ({a_busy, a_grant, a_eng_start} !== 3'b000) begin miscompares++; $display("FAIL midreset_ctrl: got %b want 000", {a_busy, a_grant, a_eng_start}); end
    vectors++; if (a_eng_data !== 24'h000000) begin miscompares++; $display("FAIL midreset_data: got %h want 000000", a_eng_data); end
    vectors++; if ({a_done0, a_done1, a_err0, a_err1} !== 4'b0000) begin miscompares++; $display("FAIL midreset_pulses: got %b want 0000", {a_done0, a_done1, a_err0, a_err1}); end
    a_req1 = 0;
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    eng_done = 1;
    @(negedge clk);
    eng_done = 0;
    repeat (20) @(negedge clk);
    vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL late_done_busy: got %b want 0", a_busy); end
    vectors++; if ((a_d0 - d0) + (a_d1 - d1) + (a_e0 - e0) + (a_e1 - e1) !== 0) begin miscompares++; $display("FAIL late_done_pulses: got %0d want 0", (a_d0 - d0) + (a_d1 - d1) + (a_e0 - e0) + (a_e1 - e1)); end
    vectors++; if (a_starts - s !== 1) begin miscompares++; $display("FAIL midreset_start_count: got %0d want 1", a_starts - s); end
    data0 = 24'h720101; a_req0 = 1;
    @(negedge clk);
    vectors++; if ({a_eng_start, a_grant} !== 2'b10) begin miscompares++; $display("FAIL first_after_reset: got start,grant=%b want 10", {a_eng_start, a_grant}); end
    vectors++; if (a_eng_data !== 24'h720101) begin miscompares++; $display("FAIL first_after_reset_data: got %h want 720101", a_eng_data); end
    @(negedge clk);
    eng_done = 1;
    @(negedge clk);
    eng_done = 0;
    vectors++; if (a_done0 !== 1'b1) begin miscompares++; $display("FAIL first_after_reset_done: got %b want 1", a_done0); end
    a_req0 = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin();
    int s, d0, d1, e, n;
    logic       exp_g;
    logic [23:0] exp_d;
    s = b_starts; d0 = b_d0; d1 = b_d1; e = b_e0 + b_e1;
    data0 = 24'h720a0a; data1 = 24'h72b0b0; b_req0 = 1; b_req1 = 1;
    for (int t = 0; t < 4; t++) begin
      exp_g = (t % 2 == 1);
      exp_d = exp_g ? 24'h72b0b0 : 24'h720a0a;
      n = 0;
      while (!b_eng_start && n < 10) begin @(negedge clk); n++; end
      vectors++; if (b_eng_start !== 1'b1) begin miscompares++; $display("FAIL rr_start[%0d]: got %b want 1", t, b_eng_start); end
      vectors++; if (b_grant !== exp_g) begin miscompares++; $display("FAIL rr_grant[%0d]: got %b want %b", t, b_grant, exp_g); end
      vectors++; if (b_eng_data !== exp_d) begin miscompares++; $display("FAIL rr_data[%0d]: got %h want %h", t, b_eng_data, exp_d); end
      repeat (2) @(negedge clk);
      eng_done = 1;
      @(negedge clk);
      eng_done = 0;
      vectors++; if ({b_done1, b_done0} !== (exp_g ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL rr_done[%0d]: got %b want %b", t, {b_done1, b_done0}, (exp_g ? 2'b10 : 2'b01)); end
      if (t == 3) begin b_req0 = 0; b_req1 = 0; end
    end
    repeat (3) @(negedge clk);
    vectors++; if (b_starts - s !== 4) begin miscompares++; $display("FAIL rr_start_count: got %0d want 4", b_starts - s); end
    vectors++; if ((b_d0 - d0) * 10 + (b_d1 - d1) !== 22) begin miscompares++; $display("FAIL rr_done_counts: got d0=%0d d1=%0d want 2 2", b_d0 - d0, b_d1 - d1); end
    vectors++; if (b_e0 + b_e1 - e !== 0) begin miscompares++; $display("FAIL rr_err_count: got %0d want 0", b_e0 + b_e1 - e); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 0;
    test_reset();
    test_single_write();
    test_simultaneous();
    test_timeout();
    test_collision();
    test_reset_mid();
    test_round_robin();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
